oric_tap_recorder: RTL

- Tape capture path, the reverse of the TAP player: decodes the Oric cassette output (K7_TAPEOUT, fast format) into bytes.
- Each decoded byte is pushed to SDRAM port2 through a toggle req/ack handshake; the written bytes form a TAP image.
- Sits beside the tape player in the top level on the system clock, with the same 1 MHz clock-enable.

---
 rtl/oric_tap_recorder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/oric_tap_recorder.sv
// Oric cassette capture: decodes the fast-format K7_TAPEOUT pulse train into
// bytes and hands each one to SDRAM port2 over a toggle req/ack handshake.
// Optional feature macro: ORIC_TAPREC_PARITY_EN enables odd-parity checking;
// without it the parity bit is consumed and ignored and parity_err stays 0.
module oric_tap_recorder #(
  parameter int ONE_MAX    = 520,
  parameter int MIN_PERIOD = 200,
  parameter int TIMEOUT    = 4000,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              ce,
  input  logic              record,
  input  logic              tape_in,
  output logic              byte_req,
  input  logic              byte_ack,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [7:0]        byte_data,
  output logic [ADDR_W-1:0] byte_count,
  output logic              recording,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(ONE_MAX);

  typedef enum logic [2:0] {IDLE, HUNT, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic              tape_s1_q, tape_s1_d, tape_s2_q, tape_s2_d, tape_prev_q, tape_prev_d;
  logic              record_q, record_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              have_ref_q, have_ref_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              byte_req_q, byte_req_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic [ADDR_W-1:0] byte_count_q, byte_count_d;
  logic              recording_q, recording_d;
  logic              overrun_q, overrun_d;
`ifdef ORIC_TAPREC_PARITY_EN
  logic              par_q, par_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic rise, timeout, bit_vld, bit_val, ack_evt, commit_try;

  // Next-state logic: edge timing, bit classification, framing FSM, handshake
  always_comb begin
    tape_s1_d    = tape_in;
    tape_s2_d    = tape_s1_q;
    tape_prev_d  = tape_s2_q;
    record_d     = record;
    state_d      = state_q;
    cnt_d        = cnt_q;
    have_ref_d   = have_ref_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_req_d   = byte_req_q;
    pend_d       = pend_q;
    byte_addr_d  = byte_addr_q;
    byte_data_d  = byte_data_q;
    byte_count_d = byte_count_q;
    recording_d  = recording_q;
    overrun_d    = overrun_q;
`ifdef ORIC_TAPREC_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif
    rise       = tape_s2_q & ~tape_prev_q;
    timeout    = (state_q != IDLE) && (cnt_q == TIMEOUT_C);
    bit_vld    = 1'b0;
    bit_val    = 1'b0;
    commit_try = 1'b0;

    if (ce && (cnt_q != TIMEOUT_C)) cnt_d = cnt_q + 1'b1;

    // The acknowledge is handled first so a commit in the same cycle sees an idle handshake.
    ack_evt = pend_q && (byte_ack == byte_req_q);
    if (ack_evt) begin
      pend_d       = 1'b0;
      byte_addr_d  = byte_addr_q + 1'b1;
      byte_count_d = byte_count_q + 1'b1;
    end

    if (!record) begin
      state_d     = IDLE;
      recording_d = 1'b0;
      have_ref_d  = 1'b0;
    end else if (!record_q) begin
      state_d      = HUNT;
      recording_d  = 1'b1;
      have_ref_d   = 1'b0;
      byte_addr_d  = '0;
      byte_count_d = '0;
      overrun_d    = 1'b0;
`ifdef ORIC_TAPREC_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end else if (state_q != IDLE) begin
      if (timeout) begin
        state_d    = HUNT;
        have_ref_d = 1'b0;
      end
      if (rise) begin
        if (!have_ref_q || timeout) begin
          cnt_d      = '0;
          have_ref_d = 1'b1;
        end else if (cnt_q >= MIN_C) begin
          cnt_d   = '0;
          bit_vld = 1'b1;
          bit_val = (cnt_q <= ONE_C);
        end
      end
      if (bit_vld) begin
        case (state_q)
          HUNT: begin
            if (!bit_val) begin
              state_d   = DATA;
              bit_idx_d = '0;
              shreg_d   = '0;
            end
          end
          DATA: begin
            shreg_d   = {bit_val, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_d = PARITY;
          end
          PARITY: begin
`ifdef ORIC_TAPREC_PARITY_EN
            par_d = bit_val;
`endif
            state_d = STOP;
          end
          STOP: begin
            if (bit_val) begin
              state_d    = HUNT;
              commit_try = 1'b1;
`ifdef ORIC_TAPREC_PARITY_EN
              if (^{shreg_q, par_q} == 1'b0) begin
                commit_try   = 1'b0;
                parity_err_d = 1'b1;
              end
`endif
            end else begin
              state_d   = DATA;
              bit_idx_d = '0;
              shreg_d   = '0;
            end
          end
          default: ;
        endcase
      end
    end

    if (commit_try) begin
      if (byte_req_q == byte_ack) begin
        byte_data_d = shreg_q;
        byte_req_d  = ~byte_req_q;
        pend_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= IDLE;
      tape_s1_q    <= 1'b0;
      tape_s2_q    <= 1'b0;
      tape_prev_q  <= 1'b0;
      record_q     <= 1'b0;
      cnt_q        <= '0;
      have_ref_q   <= 1'b0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_req_q   <= 1'b0;
      pend_q       <= 1'b0;
      byte_addr_q  <= '0;
      byte_data_q  <= '0;
      byte_count_q <= '0;
      recording_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef ORIC_TAPREC_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tape_s1_q    <= tape_s1_d;
      tape_s2_q    <= tape_s2_d;
      tape_prev_q  <= tape_prev_d;
      record_q     <= record_d;
      cnt_q        <= cnt_d;
      have_ref_q   <= have_ref_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_req_q   <= byte_req_d;
      pend_q       <= pend_d;
      byte_addr_q  <= byte_addr_d;
      byte_data_q  <= byte_data_d;
      byte_count_q <= byte_count_d;
      recording_q  <= recording_d;
      overrun_q    <= overrun_d;
`ifdef ORIC_TAPREC_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign byte_req   = byte_req_q;
  assign byte_addr  = byte_addr_q;
  assign byte_data  = byte_data_q;
  assign byte_count = byte_count_q;
  assign recording  = recording_q;
  assign overrun    = overrun_q;
`ifdef ORIC_TAPREC_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
